// File: rtl/pdm_modulator.sv
// First-order sigma-delta PDM modulator fed by a small PCM FIFO.
// Each PCM sample is held for interpolation_factor_i PDM strobes; an empty FIFO falls back to midscale.
module pdm_modulator #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             reset_modulator_i,
    input  logic [31:0]      interpolation_factor_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] pcm_i,
    input  logic             pcm_valid_i,
    output logic             pcm_ready_o,
    input  logic             strobe_i,
    output logic             pdm_o,
    output logic             pdm_valid_o,
    output logic             underflow_o,
    output logic             invalid_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic [WIDTH-1:0] fifo_head, stored_sample;
    logic             push, pop, active;

    state_t           state, state_next;
    logic [31:0]      hold_cnt, hold_cnt_next;
    logic [WIDTH-1:0] cur_sample, cur_sample_next, mod_sample;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;
    logic             underflow_next;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_head  = mem[rd_ptr[AW-1:0]];

    assign pcm_ready_o   = !fifo_full;
    assign invalid_o     = (interpolation_factor_i == 32'd0);
    assign stored_sample = signed_i ? {~pcm_i[WIDTH-1], pcm_i[WIDTH-2:0]} : pcm_i;
    assign push          = pcm_valid_i && pcm_ready_o && !reset_modulator_i;
    assign active        = strobe_i && !invalid_o && !reset_modulator_i;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        pop             = 1'b0;
        state_next      = state;
        hold_cnt_next   = hold_cnt;
        cur_sample_next = cur_sample;
        mod_sample      = cur_sample;
        underflow_next  = 1'b0;
        if (active) begin
            if (state == RUN && hold_cnt != 32'd0) begin
                hold_cnt_next = hold_cnt - 32'd1;
            end else if (!fifo_empty) begin
                pop             = 1'b1;
                cur_sample_next = fifo_head;
                mod_sample      = fifo_head;
                hold_cnt_next   = interpolation_factor_i - 32'd1;
                state_next      = RUN;
            end else begin
                underflow_next  = (state == RUN);
                state_next      = IDLE;
                cur_sample_next = MIDSCALE;
                mod_sample      = MIDSCALE;
            end
        end
    end

    assign sum = {1'b0, acc} + {1'b0, mod_sample};

    // NOTE: the sample storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= stored_sample;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= IDLE;
            hold_cnt    <= '0;
            cur_sample  <= MIDSCALE;
            acc         <= '0;
            pdm_o       <= 1'b0;
            pdm_valid_o <= 1'b0;
            underflow_o <= 1'b0;
        end else if (reset_modulator_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= IDLE;
            hold_cnt    <= '0;
            cur_sample  <= MIDSCALE;
            acc         <= '0;
            pdm_o       <= 1'b0;
            pdm_valid_o <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            pdm_valid_o <= active;
            underflow_o <= underflow_next;
            if (active) begin
                state      <= state_next;
                hold_cnt   <= hold_cnt_next;
                cur_sample <= cur_sample_next;
                acc        <= sum[WIDTH-1:0];
                pdm_o      <= sum[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_pdm_modulator.sv
// Self-checking bench for pdm_modulator: directed scenarios plus randomized traffic
// compared cycle by cycle with a queue-based behavioural model.
module tb_pdm_modulator;

    localparam int W     = 16;
    localparam int DEPTH = 2;
    localparam int MID   = 32768;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          reset_modulator_i;
    logic [31:0]   interpolation_factor_i;
    logic          signed_i;
    logic [W-1:0]  pcm_i;
    logic          pcm_valid_i;
    logic          pcm_ready_o;
    logic          strobe_i;
    logic          pdm_o;
    logic          pdm_valid_o;
    logic          underflow_o;
    logic          invalid_o;

    pdm_modulator #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i                  (clk_i),
        .rst_n_i                (rst_n_i),
        .reset_modulator_i      (reset_modulator_i),
        .interpolation_factor_i (interpolation_factor_i),
        .signed_i               (signed_i),
        .pcm_i                  (pcm_i),
        .pcm_valid_i            (pcm_valid_i),
        .pcm_ready_o            (pcm_ready_o),
        .strobe_i               (strobe_i),
        .pdm_o                  (pdm_o),
        .pdm_valid_o            (pdm_valid_o),
        .underflow_o            (underflow_o),
        .invalid_o              (invalid_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of stored samples, the sample in play and how many
    // more strobes it still owns, and the accumulator as a plain integer.
    int     q[$];
    bit     running;
    longint remain;
    int     cur;
    int     acc;
    bit     exp_pdm, exp_valid, exp_uf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        running = 0;
        remain  = 0;
        cur     = MID;
        acc     = 0;
        exp_pdm = 0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock, update model, check registered outputs.
    task automatic step(input logic rm, input logic [31:0] fac, input logic sg,
                        input logic [W-1:0] pcm, input logic pv, input logic st);
        int  s, sum;
        bit  wr;
        reset_modulator_i      = rm;
        interpolation_factor_i = fac;
        signed_i               = sg;
        pcm_i                  = pcm;
        pcm_valid_i            = pv;
        strobe_i               = st;
        #1;
        check("ready", pcm_ready_o, 32'(q.size() < DEPTH));
        check("invalid", invalid_o, 32'(fac == 0));
        @(posedge clk_i);
        exp_valid = 0;
        exp_uf    = 0;
        if (rm) begin
            model_clear();
        end else begin
            wr = pv && (q.size() < DEPTH);
            if (st && fac != 0) begin
                exp_valid = 1;
                if (running && remain > 0) begin
                    remain--;
                    s = cur;
                end else if (q.size() > 0) begin
                    cur     = q.pop_front();
                    remain  = longint'(fac) - 1;
                    running = 1;
                    s       = cur;
                end else begin
                    exp_uf  = running;
                    running = 0;
                    cur     = MID;
                    s       = MID;
                end
                sum     = acc + s;
                exp_pdm = (sum >= 65536);
                acc     = sum % 65536;
            end
            if (wr) q.push_back(sg ? int'(pcm ^ 16'h8000) : int'(pcm));
        end
        #1;
        check("pdm", pdm_o, 32'(exp_pdm));
        check("pdm_valid", pdm_valid_o, 32'(exp_valid));
        check("underflow", underflow_o, 32'(exp_uf));
    endtask

    initial begin
        logic [3:0] fs_bits;
        logic [31:0] fac;
        rst_n_i                = 1'b0;
        reset_modulator_i      = 1'b0;
        interpolation_factor_i = 32'd0;
        signed_i               = 1'b0;
        pcm_i                  = '0;
        pcm_valid_i            = 1'b0;
        strobe_i               = 1'b0;
        model_clear();
        #12;
        check("rst_ready", pcm_ready_o, 1);
        check("rst_pdm", pdm_o, 0);
        check("rst_valid", pdm_valid_o, 0);
        check("rst_uf", underflow_o, 0);
        check("rst_invalid", invalid_o, 1);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Idle silence: midscale alternates 0,1 and never underflows.
        for (int i = 0; i < 8; i++) begin
            step(0, 64, 0, 0, 0, 1);
            check("idle_bit", pdm_o, 32'(i % 2));
            check("idle_uf", underflow_o, 0);
            for (int j = 0; j < 31; j++) step(0, 64, 0, 0, 0, 0);
        end

        // Full scale 0xFFFF, factor 4: bits 0,1,1,1 then underflow.
        step(1, 4, 0, 0, 0, 0);
        step(0, 4, 0, 16'hFFFF, 1, 0);
        fs_bits = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            step(0, 4, 0, 0, 0, 1);
            check("fs_bit", pdm_o, 32'(fs_bits[i]));
            check("fs_no_uf", underflow_o, 0);
        end
        step(0, 4, 0, 0, 0, 1);
        check("fs_uf", underflow_o, 1);

        // Signed zero becomes midscale: alternating output for the held duration.
        step(1, 4, 0, 0, 0, 0);
        step(0, 4, 1, 16'h0000, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 4, 0, 0, 0, 1);
            check("signed_bit", pdm_o, 32'(i % 2));
        end

        // Backpressure: third back-to-back write waits for the first pop.
        step(1, 4, 0, 0, 0, 0);
        step(0, 4, 0, 16'h1111, 1, 0);
        step(0, 4, 0, 16'h2222, 1, 0);
        check("bp_full", pcm_ready_o, 0);
        step(0, 4, 0, 16'h3333, 1, 0);
        step(0, 4, 0, 16'h3333, 1, 1);
        check("bp_after_pop", pcm_ready_o, 1);
        step(0, 4, 0, 16'h3333, 1, 0);
        check("bp_accepted", pcm_ready_o, 0);

        // Invalid factor freezes the modulator; factor 2 resumes from the held state.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);
        check("inv_full", pcm_ready_o, 0);
        for (int i = 0; i < 6; i++) step(0, 2, 0, 0, 0, 1);

        // Reset mid-run with two buffered samples.
        step(0, 3, 0, 16'hC000, 1, 0);
        step(0, 3, 0, 16'h4000, 1, 1);
        step(0, 3, 0, 16'hA000, 1, 0);
        step(0, 3, 0, 16'hB000, 1, 0);
        step(1, 3, 0, 0, 0, 1);
        check("rm_ready", pcm_ready_o, 1);
        check("rm_pdm", pdm_o, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 3, 0, 0, 0, 1);
            check("rm_mid_bit", pdm_o, 32'(i % 2));
        end

        // Randomized traffic against the model.
        fac = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) fac = $urandom_range(0, 5);
            step($urandom_range(0, 199) == 0, fac, 1'($urandom), W'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
